toggle_ff: RTL and testbench
============================

# toggle_ff

Parameterised bank of toggle (T-type) flip-flops sharing one clock and one synchronous active-low reset. Each bit of `Q` inverts on a rising clock edge when its `T` bit is 1 and holds when it is 0. It is the state-register primitive for gate-level FSMs, such as the vending-machine controller. There, three 1-bit instances hold state bits A/B/C, and combinational next-state logic drives their `T` inputs.

## Interface
- `WIDTH`, default 1: number of independent toggle bits (≥1).
- `RESET_VAL`, default all-zeros (`WIDTH` bits): value loaded into `Q` during reset.
- `clock`  input  1  sole clock; all state changes on its rising edge.
- `reset`  input  1  synchronous, active-low reset. Sampled only on the rising edge of `clock`.
- `T`  input  `WIDTH`  per-bit toggle enable.
- `Q`  output  `WIDTH`  registered state.

Port order for positional instantiation is `clock, reset, T, Q`. Existing FSM code connects the ports by position.

## Operation
- On each rising edge of `clock`:
  - if `reset` == 0: `Q` <= `RESET_VAL`;
  - else: `Q` <= `Q` XOR `T`, bitwise.
- Reset has priority over `T`. `T` is ignored on any edge where `reset` is low.
- Bits are fully independent; there is no carry or interaction between bits.
- `Q` is driven directly from flops. There is no combinational path from `T` or `reset` to `Q`.
- `T` = X or Z outside reset is not a legal stimulus. Behaviour is not defined beyond standard simulator X-propagation.
- Power-up value before the first reset edge is undefined (X in simulation). Users must apply reset for at least one rising edge.

## Timing
- Latency: 1 cycle. A `T` bit high at edge n gives an inverted `Q` bit after edge n.
- Reset value: `Q` = `RESET_VAL` after the first rising edge with `reset` low. It holds for every further edge while `reset` stays low.
- Reset deassertion: the first edge with `reset` high evaluates `T` normally. Toggling can occur on that very edge.
- Asserting reset mid-operation: `Q` returns to `RESET_VAL` at the next rising edge regardless of `T`. Between edges `Q` keeps its previous value; it is not cleared asynchronously.
- `T` held high continuously: each bit alternates every cycle, a divide-by-2 of `clock`.
- `reset` and `T` need setup and hold only around the rising edge. Glitches between edges have no effect.
- No intrinsic gate delays are modelled. Any `#` delays belong to the surrounding gate-level netlist, not to this block.

## Structure
- Single module `toggle_ff` with no sub-modules.
- No shared package is needed. `WIDTH` and `RESET_VAL` are the only configuration values.
- Users that need per-bit naming (QA/QB/QC) instantiate `WIDTH`=1 copies.

## Test plan
- Reset: `reset`=0, `T`=1 for 3 edges → `Q`=0 after each edge, with `WIDTH`=1 and `RESET_VAL`=0.
- Hold: `reset`=1, `T`=0 for 4 edges, starting from `Q`=0 → `Q` stays 0. Repeat from `Q`=1 → `Q` stays 1.
- Toggle: `reset`=1, `T`=1 for 4 edges, starting from `Q`=0 → `Q` after each edge is 1, 0, 1, 0.
- Reset mid-toggle: set `Q`=1, then drive `reset`=0 with `T`=1 for one edge → `Q`=0. Next edge with `reset`=1, `T`=1 → `Q`=1.
- Multi-bit: `WIDTH`=4, `RESET_VAL`=4'b1010, then reset. Apply `T`=4'b0110, then `T`=4'b1111 → `Q`=4'b1100, then 4'b0011.
- Per-edge check: randomised `T`/`reset` for 200 cycles against a reference model `Q_next = !reset ? RESET_VAL : Q ^ T` → zero mismatches.

Source files
------------

// File: rtl/toggle_ff.sv
// Bank of independent T-type flip-flops with a shared clock and a synchronous
// active-low reset. Every bit of Q inverts on a rising clock edge when its T
// bit is 1. Reset takes priority over T and loads RESET_VAL.
// FSM code connects this block by position, so the port order must remain
// clock, reset, T, Q.
module toggle_ff #(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] T,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next state: each bit flips where its T bit is set. Bits do not interact.
  always_comb begin
    q_d = q_q ^ T;
  end

  // State register. Reset is sampled on the clock edge only and wins over T.
  // NOTE: use non-blocking (<=) here so every flop samples pre-edge values;
  // blocking assignments in clocked blocks create simulation races.
  always_ff @(posedge clock) begin
    if (!reset) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  // Q is driven straight from the flops. T and reset have no combinational path to it.
  assign Q = q_q;

endmodule

// File: tb/tb_toggle_ff.sv
// Directed and randomised self-checking bench for toggle_ff. It covers a
// 1-bit instance with reset value 0 and a 4-bit instance with reset value 4'b1010.
module tb_toggle_ff;

  logic       clk = 1'b0;
  logic       rst1;
  logic       t1;
  logic       q1;
  logic       rst4;
  logic [3:0] t4;
  logic [3:0] q4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  toggle_ff #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
    .clock (clk),
    .reset (rst1),
    .T     (t1),
    .Q     (q1)
  );

  toggle_ff #(.WIDTH(4), .RESET_VAL(4'b1010)) dut4 (
    .clock (clk),
    .reset (rst4),
    .T     (t4),
    .Q     (q4)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, act[3:0], exp[3:0]);
    end
  endtask

  // Drive the 1-bit instance away from the edge, clock once, then check shortly after the edge.
  task automatic step1(input logic r, input logic t, input logic exp, input string tag);
    @(negedge clk);
    rst1 = r;
    t1   = t;
    @(posedge clk);
    #1;
    check(tag, 32'(q1), 32'(exp));
  endtask

  task automatic step4(input logic r, input logic [3:0] t, input logic [3:0] exp, input string tag);
    @(negedge clk);
    rst4 = r;
    t4   = t;
    @(posedge clk);
    #1;
    check(tag, 32'(q4), 32'(exp));
  endtask

  initial begin
    logic [3:0] model;
    logic       r;
    logic [3:0] t;

    rst1 = 1'b0;
    t1   = 1'b1;
    rst4 = 1'b0;
    t4   = 4'b1111;

    // Reset for three edges with T high. Q must stay at the reset value.
    for (int i = 0; i < 3; i++) step1(1'b0, 1'b1, 1'b0, "w1_reset");

    // Hold at 0.
    for (int i = 0; i < 4; i++) step1(1'b1, 1'b0, 1'b0, "w1_hold0");
    // Move to 1, then hold at 1.
    step1(1'b1, 1'b1, 1'b1, "w1_to1");
    for (int i = 0; i < 4; i++) step1(1'b1, 1'b0, 1'b1, "w1_hold1");
    // Move back to 0, then toggle on four edges: 1, 0, 1, 0.
    step1(1'b1, 1'b1, 1'b0, "w1_to0");
    step1(1'b1, 1'b1, 1'b1, "w1_tog_a");
    step1(1'b1, 1'b1, 1'b0, "w1_tog_b");
    step1(1'b1, 1'b1, 1'b1, "w1_tog_c");
    step1(1'b1, 1'b1, 1'b0, "w1_tog_d");

    // Reset mid-toggle. Q is 1, then reset with T high gives 0, then release toggles on the first edge.
    step1(1'b1, 1'b1, 1'b1, "w1_set1");
    step1(1'b0, 1'b1, 1'b0, "w1_midrst");
    step1(1'b1, 1'b1, 1'b1, "w1_release");

    // 4-bit instance. Load the reset value, then apply two toggle patterns.
    step4(1'b0, 4'b1111, 4'b1010, "w4_reset");
    step4(1'b0, 4'b0101, 4'b1010, "w4_reset_hold");
    step4(1'b1, 4'b0110, 4'b1100, "w4_t0110");
    step4(1'b1, 4'b1111, 4'b0011, "w4_t1111");

    // Randomised per-edge comparison against the reference model.
    model = 4'b0011;
    for (int i = 0; i < 200; i++) begin
      r     = ($urandom_range(0, 7) != 0);
      t     = 4'($urandom_range(0, 15));
      model = !r ? 4'b1010 : (model ^ t);
      step4(r, t, model, "w4_random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
